// File: rtl/ecc_secded_wr_encoder_if.sv
// Write-request channel into the SECDED write encoder.
// Handshake: a request transfers on any rising clock edge where both
// wr_valid_i and wr_ready_o are high. While wr_valid_i is high and
// wr_ready_o is low, the requester holds wr_addr_i, wr_strobe_i and data_in stable.
interface ecc_secded_wr_encoder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
);
    logic                  wr_valid_i;
    logic                  wr_ready_o;
    logic [ADDR_WIDTH-1:0] wr_addr_i;
    logic [STRB_WIDTH-1:0] wr_strobe_i;
    logic [DATA_WIDTH-1:0] data_in;

    modport master (
        output wr_valid_i, wr_addr_i, wr_strobe_i, data_in,
        input  wr_ready_o
    );

    modport slave (
        input  wr_valid_i, wr_addr_i, wr_strobe_i, data_in,
        output wr_ready_o
    );
endinterface

// File: rtl/ecc_secded_wr_encoder.sv
// SECDED write-path encoder. Full-strobe writes are encoded in a two-stage
// pipeline. Partial-strobe writes perform a read-modify-write:
// IDLE -> DRAIN -> RD_REQ -> RD_WAIT -> IDLE.
// Codeword: position i >= 1 is Hamming position i, check bit k is at 2^k,
// and bit 0 is overall parity.
module ecc_secded_wr_encoder #(
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int PARITY_BITS       = 6,
    parameter int STRB_WIDTH        = DATA_WIDTH / 8,
    parameter int MEMORY_DATA_WIDTH = DATA_WIDTH + PARITY_BITS + 1
) (
    input  logic                         ecc_enc_clk,
    input  logic                         ecc_enc_rst,
    input  logic                         ecc_enc_sw_rst,
    input  logic                         ecc_en,
    ecc_secded_wr_encoder_if.slave       wr_if,
    output logic                         rd_req_o,
    output logic [ADDR_WIDTH-1:0]        rd_addr_o,
    input  logic                         rd_valid_i,
    input  logic [MEMORY_DATA_WIDTH-1:0] rd_data_i,
    output logic                         wr_en_o,
    output logic [ADDR_WIDTH-1:0]        wr_addr_o,
    output logic [MEMORY_DATA_WIDTH-1:0] encoded_data,
    output logic [1:0]                   dbg_state_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRAIN   = 2'd1;
    localparam logic [1:0] ST_RD_REQ  = 2'd2;
    localparam logic [1:0] ST_RD_WAIT = 2'd3;

    // Place data bits at the non-power-of-two positions. When enabled, also
    // compute the check bits and the overall parity bit.
    function automatic logic [MEMORY_DATA_WIDTH-1:0] f_encode(
        input logic [DATA_WIDTH-1:0] d,
        input logic                  en
    );
        logic [MEMORY_DATA_WIDTH-1:0] cw;
        logic                         par;
        int                           di;
        cw = '0;
        di = 0;
        for (int p = 1; p < MEMORY_DATA_WIDTH; p++) begin
            if ((p & (p - 1)) != 0 && di < DATA_WIDTH) begin
                cw[p] = d[di];
                di++;
            end
        end
        if (en) begin
            for (int k = 0; k < PARITY_BITS; k++) begin
                par = 1'b0;
                for (int p = 1; p < MEMORY_DATA_WIDTH; p++) begin
                    if (((p >> k) & 1) == 1) par ^= cw[p];
                end
                if ((1 << k) < MEMORY_DATA_WIDTH) cw[1 << k] = par;
            end
            cw[0] = ^cw[MEMORY_DATA_WIDTH-1:1];
        end
        return cw;
    endfunction

    // Raw data-bit extraction from a stored codeword. No correction is applied.
    function automatic logic [DATA_WIDTH-1:0] f_extract(
        input logic [MEMORY_DATA_WIDTH-1:0] cw
    );
        logic [DATA_WIDTH-1:0] d;
        int                    di;
        d  = '0;
        di = 0;
        for (int p = 1; p < MEMORY_DATA_WIDTH; p++) begin
            if ((p & (p - 1)) != 0 && di < DATA_WIDTH) begin
                d[di] = cw[p];
                di++;
            end
        end
        return d;
    endfunction

    logic [1:0]                   r_state;
    logic                         r_ready;
    logic                         r_rd_req;
    logic [ADDR_WIDTH-1:0]        r_rd_addr;
    logic [ADDR_WIDTH-1:0]        r_rmw_addr;
    logic [DATA_WIDTH-1:0]        r_rmw_data;
    logic [STRB_WIDTH-1:0]        r_rmw_strb;
    logic                         r_s1_valid;
    logic [ADDR_WIDTH-1:0]        r_s1_addr;
    logic [DATA_WIDTH-1:0]        r_s1_data;
    logic                         r_wr_en;
    logic [ADDR_WIDTH-1:0]        r_wr_addr;
    logic [MEMORY_DATA_WIDTH-1:0] r_enc;

    logic                         w_accept;
    logic                         w_full;
    logic                         w_partial;
    logic                         w_rmw_done;
    logic [1:0]                   w_state_nxt;
    logic [DATA_WIDTH-1:0]        w_old_data;
    logic [DATA_WIDTH-1:0]        w_merged;

    assign w_accept   = wr_if.wr_valid_i && r_ready;
    assign w_full     = &wr_if.wr_strobe_i;
    assign w_partial  = !w_full && (|wr_if.wr_strobe_i);
    assign w_rmw_done = (r_state == ST_RD_WAIT) && rd_valid_i;
    assign w_old_data = f_extract(rd_data_i);

    // Byte merge: strobed bytes take the new data, the rest keep the old data.
    always_comb begin
        w_merged = w_old_data;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (r_rmw_strb[b]) w_merged[b*8 +: 8] = r_rmw_data[b*8 +: 8];
        end
    end

    // Next-state logic for the read-modify-write sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_accept && w_partial) w_state_nxt = ST_DRAIN;
            ST_DRAIN:   w_state_nxt = ST_RD_REQ;
            ST_RD_REQ:  w_state_nxt = ST_RD_WAIT;
            ST_RD_WAIT: if (rd_valid_i) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Sequencer state, registered handshake/read outputs, and RMW request capture.
    always_ff @(posedge ecc_enc_clk or posedge ecc_enc_rst) begin
        if (ecc_enc_rst) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_rd_req   <= 1'b0;
            r_rd_addr  <= '0;
            r_rmw_addr <= '0;
            r_rmw_data <= '0;
            r_rmw_strb <= '0;
        end else if (ecc_enc_sw_rst) begin
            r_state    <= ST_IDLE;
            r_ready    <= 1'b1;
            r_rd_req   <= 1'b0;
            r_rd_addr  <= '0;
            r_rmw_addr <= '0;
            r_rmw_data <= '0;
            r_rmw_strb <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= (w_state_nxt == ST_IDLE);
            r_rd_req <= (w_state_nxt == ST_RD_REQ);
            if (w_state_nxt == ST_RD_REQ) r_rd_addr <= r_rmw_addr;
            if (w_accept && w_partial) begin
                r_rmw_addr <= wr_if.wr_addr_i;
                r_rmw_data <= wr_if.data_in;
                r_rmw_strb <= wr_if.wr_strobe_i;
            end
        end
    end

    // Stage 1 captures full-strobe writes. Zero-strobe requests are dropped here.
    always_ff @(posedge ecc_enc_clk or posedge ecc_enc_rst) begin
        if (ecc_enc_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_data  <= '0;
        end else if (ecc_enc_sw_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= w_accept && w_full;
            if (w_accept && w_full) begin
                r_s1_addr <= wr_if.wr_addr_i;
                r_s1_data <= wr_if.data_in;
            end
        end
    end

    // Stage 2 encodes either the pipelined word or the merged RMW word.
    // The DRAIN state guarantees both sources are never active together.
    always_ff @(posedge ecc_enc_clk or posedge ecc_enc_rst) begin
        if (ecc_enc_rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_enc     <= '0;
        end else if (ecc_enc_sw_rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_enc     <= '0;
        end else if (r_s1_valid) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_s1_addr;
            r_enc     <= f_encode(r_s1_data, ecc_en);
        end else if (w_rmw_done) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_rmw_addr;
            r_enc     <= f_encode(w_merged, ecc_en);
        end else begin
            r_wr_en   <= 1'b0;
        end
    end

    assign wr_if.wr_ready_o = r_ready;
    assign rd_req_o         = r_rd_req;
    assign rd_addr_o        = r_rd_addr;
    assign wr_en_o          = r_wr_en;
    assign wr_addr_o        = r_wr_addr;
    assign encoded_data     = r_enc;
    assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_ecc_secded_wr_encoder.sv
// Testbench for ecc_secded_wr_encoder (DATA_WIDTH=32): directed cases plus
// randomized mixed full, partial and dropped writes. Expected codewords come
// from a syndrome-style reference encoder and a word-level memory model.
module tb_ecc_secded_wr_encoder;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int PB = 6;
  localparam int MW = DW + PB + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  logic sw_rst;
  logic ecc_en;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [MW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [MW-1:0] enc;
  logic [1:0]    dbg_state;

  ecc_secded_wr_encoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) wr_if ();

  ecc_secded_wr_encoder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARITY_BITS(PB)
  ) dut (
    .ecc_enc_clk(clk),
    .ecc_enc_rst(rst),
    .ecc_enc_sw_rst(sw_rst),
    .ecc_en(ecc_en),
    .wr_if(wr_if),
    .rd_req_o(rd_req),
    .rd_addr_o(rd_addr),
    .rd_valid_i(rd_valid),
    .rd_data_i(rd_data),
    .wr_en_o(wr_en),
    .wr_addr_o(wr_addr),
    .encoded_data(enc),
    .dbg_state_o(dbg_state)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  // entry: [87] ecc_en, [86:71] write cycle, [70:39] address, [38:0] codeword
  logic [87:0] exp_q[$];
  logic [MW-1:0] mem[0:15];
  logic [MW-1:0] last_cw = '0;
  int rdreq_cnt = 0;
  int exp_rdreq = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // reference model: the check bits equal the XOR of the positions of all set data bits
  function automatic logic [MW-1:0] m_encode(input logic [DW-1:0] d, input logic en);
    logic [MW-1:0] cw;
    int p;
    int syn;
    cw = '0;
    p = 1;
    syn = 0;
    for (int i = 0; i < DW; i++) begin
      while ((p & (p - 1)) == 0) p++;
      cw[p] = d[i];
      if (d[i]) syn ^= p;
      p++;
    end
    if (en) begin
      for (int k = 0; k < PB; k++) cw[1 << k] = ((syn >> k) & 1) == 1;
      cw[0] = ^cw[MW-1:1];
    end
    return cw;
  endfunction

  function automatic logic [DW-1:0] m_extract(input logic [MW-1:0] cw);
    logic [DW-1:0] d;
    int p;
    p = 1;
    for (int i = 0; i < DW; i++) begin
      while ((p & (p - 1)) == 0) p++;
      d[i] = cw[p];
      p++;
    end
    return d;
  endfunction

  function automatic logic [DW-1:0] m_merge(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                            input logic [3:0] s);
    logic [DW-1:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? new_d[b*8 +: 8] : old_d[b*8 +: 8];
    return r;
  endfunction

  // monitor: every memory write must match the head of the expected queue
  always @(negedge clk) begin
    logic [87:0] e;
    if (rd_req) rdreq_cnt++;
    if (wr_en) begin
      last_cw = enc;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 64'(wr_en), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(e[86:71]));
        chk("wr_addr", 64'(wr_addr), 64'(e[70:39]));
        chk("wr_codeword", 64'(enc), 64'(e[38:0]));
        if (e[87]) chk("wr_parity", 64'(^enc), 64'(0));
        mem[e[42:39]] = e[38:0];
      end
    end
  end

  // driver tasks (all start and end at 1 time unit after a rising edge)
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ecc(input logic v);
    idle(3);
    ecc_en = v;
  endtask

  task automatic send(input int a, input logic [3:0] s, input logic [DW-1:0] d, output int acc);
    int n;
    n = 0;
    wr_if.wr_valid_i  = 1'b1;
    wr_if.wr_addr_i   = AW'(a);
    wr_if.wr_strobe_i = s;
    wr_if.data_in     = d;
    @(negedge clk);
    while (!wr_if.wr_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!wr_if.wr_ready_o) begin
      chk("accept_timeout", 64'(wr_if.wr_ready_o), 64'(1));
      acc = -1;
    end else begin
      acc = cyc + 1;
    end
    @(posedge clk);
    #1;
    wr_if.wr_valid_i = 1'b0;
  endtask

  task automatic send_full(input int a, input logic [DW-1:0] d, output int acc);
    send(a, 4'hF, d, acc);
    if (acc >= 0) exp_q.push_back({ecc_en, 16'(acc + 1), AW'(a), m_encode(d, ecc_en)});
  endtask

  task automatic wait_rdreq(input int acc, input int a, output bit ok);
    int n;
    n = 0;
    while (!rd_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok = rd_req;
    chk("rdreq_cycle", 64'(rd_req ? cyc : -1), 64'(acc + 1));
    chk("rdreq_addr", 64'(rd_addr), 64'(a));
    chk("rdreq_ready_low", 64'(wr_if.wr_ready_o), 64'(0));
  endtask

  task automatic do_partial(input int a, input logic [3:0] s, input logic [DW-1:0] d, input int dly);
    int acc;
    bit ok;
    send(a, s, d, acc);
    if (acc < 0) return;
    exp_rdreq++;
    @(negedge clk);
    chk("rmw_ready_drain", 64'(wr_if.wr_ready_o), 64'(0));
    wait_rdreq(acc, a, ok);
    if (!ok) return;
    repeat (dly) @(posedge clk);
    #1;
    rd_valid = 1'b1;
    rd_data  = mem[a[3:0]];
    exp_q.push_back({ecc_en, 16'(cyc + 1), AW'(a),
                     m_encode(m_merge(m_extract(mem[a[3:0]]), d, s), ecc_en)});
    @(negedge clk);
    chk("rmw_ready_wait", 64'(wr_if.wr_ready_o), 64'(0));
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    rd_data  = {$urandom, $urandom};
    @(negedge clk);
    chk("rmw_ready_back", 64'(wr_if.wr_ready_o), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic rmw_abort(input bit use_sw);
    int acc;
    bit ok;
    send(7, 4'h3, 32'h55667788, acc);
    if (acc < 0) return;
    exp_rdreq++;
    @(negedge clk);
    wait_rdreq(acc, 7, ok);
    @(posedge clk);
    #1;
    if (use_sw) begin
      sw_rst = 1'b1;
      @(posedge clk);
      #1;
      sw_rst = 1'b0;
    end else begin
      rst = 1'b1;
      #2;
      rst = 1'b0;
    end
    @(posedge clk);
    #1;
    rd_valid = 1'b1;
    rd_data  = mem[7];
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(use_sw ? "sw_abort_no_wr" : "abort_no_wr", 64'(wr_en), 64'(0));
    end
    chk(use_sw ? "sw_abort_ready" : "abort_ready", 64'(wr_if.wr_ready_o), 64'(1));
    chk(use_sw ? "sw_abort_state" : "abort_state", 64'(dbg_state), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1);
  end

  initial begin
    int acc;
    int acc2;
    int prev;
    int a;
    int kind;
    logic [DW-1:0] d;
    rst = 1'b1;
    sw_rst = 1'b0;
    ecc_en = 1'b1;
    rd_valid = 1'b0;
    rd_data = '0;
    wr_if.wr_valid_i = 1'b0;
    wr_if.wr_addr_i = '0;
    wr_if.wr_strobe_i = '0;
    wr_if.data_in = '0;
    for (int i = 0; i < 16; i++) mem[i] = m_encode($urandom, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_ready", 64'(wr_if.wr_ready_o), 64'(1));
    chk("rst_rd_req", 64'(rd_req), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_addr", 64'(wr_addr), 64'(0));
    chk("rst_rd_addr", 64'(rd_addr), 64'(0));
    chk("rst_encoded", 64'(enc), 64'(0));
    chk("rst_state", 64'(dbg_state), 64'(0));
    @(posedge clk);
    #1;

    // single full writes with and without check-bit generation
    send_full(0, 32'h0000_0001, acc);
    idle(3);
    chk("full_ecc_on", 64'(last_cw), 64'(39'h00_0000_000F));
    set_ecc(1'b0);
    send_full(1, 32'h0000_0001, acc);
    idle(3);
    chk("full_ecc_off", 64'(last_cw), 64'(39'h00_0000_0008));
    set_ecc(1'b1);

    // back-to-back full writes
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      send_full(i, 32'(i) * 32'h0101_0101, acc);
      if (i > 0) chk("b2b_accept", 64'(acc), 64'(prev + 1));
      prev = acc;
    end
    idle(4);

    // partial write merging into a known stored word
    mem[5] = m_encode(32'h1122_3344, 1'b1);
    do_partial(5, 4'h1, 32'hAABB_CCDD, 3);
    idle(2);
    chk("rmw_codeword", 64'(last_cw), 64'(m_encode(32'h1122_33DD, 1'b1)));

    // stray read data while idle, then a dropped request followed by a full write
    rd_valid = 1'b1;
    rd_data = {$urandom, $urandom};
    @(posedge clk);
    #1;
    rd_valid = 1'b0;
    send(3, 4'h0, 32'hDEAD_BEEF, acc);
    send_full(4, 32'h0BAD_F00D, acc2);
    chk("drop_next_accept", 64'(acc2), 64'(acc + 1));
    idle(3);

    // reset while waiting for read data, hard then soft
    rmw_abort(1'b0);
    rmw_abort(1'b1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 9) set_ecc(1'($urandom_range(0, 1)));
      kind = $urandom_range(0, 9);
      a = $urandom_range(0, 15);
      d = $urandom;
      if (kind == 0) send(a, 4'h0, d, acc);
      else if (kind <= 3) do_partial(a, 4'($urandom_range(1, 14)), d, $urandom_range(1, 5));
      else send_full(a, d, acc);
    end

    idle(10);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    chk("rdreq_count", 64'(rdreq_cnt), 64'(exp_rdreq));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
